// File: rtl/memunit.sv
// ---------------------------------------------------------------------------
// memunit -- load/store unit sitting between the execute/memory stage and a
// simple valid/ready request + rvalid response memory bus.
//
// One access is in flight at a time. A three-state FSM (IDLE -> WAIT_READY ->
// WAIT_RVALID -> IDLE) launches the request, holds it until the bus accepts
// it, then waits for the response. Stores also wait for rvalid, which acts as
// the write acknowledge.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   valid_i               instruction in this stage is valid
//   is_load_i/is_store_i  instruction is a load / store
//   funct3_i              width/sign select
//   addr_i, wdata_i       effective byte address, store data (rs2)
//   stall_o               hold the pipeline on the current instruction
//   rdata_o               aligned, extended load result
//   membus_valid_o        request pending           membus_ready_i  accepted
//   membus_addr_o         request byte address      membus_wen_o    1 = write
//   membus_wdata_o        lane-aligned write data   membus_wmask_o  byte enables
//   membus_rvalid_i       response present          membus_rdata_i  read data
// ---------------------------------------------------------------------------
module memunit #(
  parameter int XLEN           = 64,
  parameter int MEM_DATA_WIDTH = 64
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        valid_i,
  input  logic                        is_load_i,
  input  logic                        is_store_i,
  input  logic [2:0]                  funct3_i,
  input  logic [XLEN-1:0]             addr_i,
  input  logic [XLEN-1:0]             wdata_i,
  output logic                        stall_o,
  output logic [XLEN-1:0]             rdata_o,
  output logic                        membus_valid_o,
  input  logic                        membus_ready_i,
  output logic [XLEN-1:0]             membus_addr_o,
  output logic                        membus_wen_o,
  output logic [MEM_DATA_WIDTH-1:0]   membus_wdata_o,
  output logic [MEM_DATA_WIDTH/8-1:0] membus_wmask_o,
  input  logic                        membus_rvalid_i,
  input  logic [MEM_DATA_WIDTH-1:0]   membus_rdata_i
);

  localparam int MW   = MEM_DATA_WIDTH / 8;   // byte lanes on the bus
  localparam int OFFW = $clog2(MW);           // lane-select bits of the address

  localparam logic [1:0] S_IDLE        = 2'd0;
  localparam logic [1:0] S_WAIT_READY  = 2'd1;
  localparam logic [1:0] S_WAIT_RVALID = 2'd2;

  // Latched copy of the access; once out of IDLE this, not the stage inputs,
  // drives the bus and the load extension.
  typedef struct packed {
    logic [XLEN-1:0]           addr;
    logic                      wen;
    logic [2:0]                funct3;
    logic [MEM_DATA_WIDTH-1:0] wdata;
    logic [MW-1:0]             wmask;
  } mem_req_t;

  logic [1:0] state_q, state_d;
  mem_req_t   req_q, req_d;

  logic                      memop;
  logic                      rsp_fire;
  logic [OFFW-1:0]           off_in;
  logic [MEM_DATA_WIDTH-1:0] wdata_lane;
  logic [MW-1:0]             mask_base;
  logic [MW-1:0]             mask_lane;

  assign memop    = valid_i && (is_load_i || is_store_i);
  assign rsp_fire = (state_q == S_WAIT_RVALID) && membus_rvalid_i;
  assign off_in   = addr_i[OFFW-1:0];

  // ---------------------------------------------------------------------
  // Store lane alignment. Bytes shifted past the top lane are dropped, so a
  // misaligned access just gets a truncated mask instead of trapping.
  // ---------------------------------------------------------------------
  assign wdata_lane = MEM_DATA_WIDTH'(wdata_i) << {off_in, 3'b000};

  always_comb begin
    mask_base = '0;
    case (funct3_i)
      3'b000:  mask_base = MW'(1);
      3'b001:  mask_base = MW'(3);
      3'b010:  mask_base = MW'(15);
      default: mask_base = '0;
    endcase
  end

  always_comb begin
    mask_lane = '0;
    if (is_store_i) begin
      // SD always enables every lane, unshifted; 1xx has no store encoding.
      if (funct3_i == 3'b011) mask_lane = '1;
      else                    mask_lane = mask_base << off_in;
    end
  end

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    case (state_q)
      S_IDLE: begin
        if (memop) begin
          state_d      = S_WAIT_READY;
          req_d.addr   = addr_i;
          req_d.wen    = is_store_i;
          req_d.funct3 = funct3_i;
          req_d.wdata  = wdata_lane;
          req_d.wmask  = mask_lane;
        end
      end
      S_WAIT_READY: begin
        if (membus_ready_i) state_d = S_WAIT_RVALID;
      end
      S_WAIT_RVALID: begin
        // No new request can leave until this response lands.
        if (membus_rvalid_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
    end
  end

  // ---------------------------------------------------------------------
  // Bus outputs. Reset forces them quiet in the same cycle, not only after
  // the registers clear, so an abandoned access never leaks onto the bus.
  // ---------------------------------------------------------------------
  always_comb begin
    membus_valid_o = 1'b0;
    membus_addr_o  = '0;
    membus_wen_o   = 1'b0;
    membus_wdata_o = '0;
    membus_wmask_o = '0;
    if (!rst_i) begin
      membus_valid_o = (state_q == S_WAIT_READY);
      membus_addr_o  = req_q.addr;
      membus_wen_o   = req_q.wen;
      membus_wdata_o = req_q.wdata;
      membus_wmask_o = req_q.wmask;
    end
  end

  // Stall drops exactly in the response cycle, which is when rdata is valid.
  assign stall_o = memop && !rsp_fire;

  // ---------------------------------------------------------------------
  // Load path: pull the addressed lane down to bit 0, then extend per the
  // latched funct3. 011 and the unused 111 both return the full word.
  // ---------------------------------------------------------------------
  logic [OFFW-1:0]           off_q;
  logic [MEM_DATA_WIDTH-1:0] rd_sh;
  logic [XLEN-1:0]           rd_lo;

  assign off_q = req_q.addr[OFFW-1:0];
  assign rd_sh = membus_rdata_i >> {off_q, 3'b000};
  assign rd_lo = XLEN'(rd_sh);

  always_comb begin
    rdata_o = rd_lo;
    case (req_q.funct3)
      3'b000:  rdata_o = {{(XLEN-8){rd_lo[7]}},   rd_lo[7:0]};
      3'b001:  rdata_o = {{(XLEN-16){rd_lo[15]}}, rd_lo[15:0]};
      3'b010:  rdata_o = {{(XLEN-32){rd_lo[31]}}, rd_lo[31:0]};
      3'b100:  rdata_o = {{(XLEN-8){1'b0}},       rd_lo[7:0]};
      3'b101:  rdata_o = {{(XLEN-16){1'b0}},      rd_lo[15:0]};
      3'b110:  rdata_o = {{(XLEN-32){1'b0}},      rd_lo[31:0]};
      default: rdata_o = rd_lo;
    endcase
  end

endmodule

// File: tb/tb_memunit.sv
module tb_memunit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, is_load, is_store;
  logic [2:0]  funct3;
  logic [63:0] addr, wdata;
  logic        stall;
  logic [63:0] rdata;
  logic        mb_valid, mb_ready, mb_wen, mb_rvalid;
  logic [63:0] mb_addr, mb_wdata, mb_rdata;
  logic [7:0]  mb_wmask;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  memunit #(.XLEN(64), .MEM_DATA_WIDTH(64)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .is_load_i(is_load),
    .is_store_i(is_store), .funct3_i(funct3), .addr_i(addr), .wdata_i(wdata),
    .stall_o(stall), .rdata_o(rdata), .membus_valid_o(mb_valid),
    .membus_ready_i(mb_ready), .membus_addr_o(mb_addr), .membus_wen_o(mb_wen),
    .membus_wdata_o(mb_wdata), .membus_wmask_o(mb_wmask),
    .membus_rvalid_i(mb_rvalid), .membus_rdata_i(mb_rdata)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (transaction level) ----------------
  function automatic logic [63:0] exp_wdata(input logic [63:0] d, input logic [63:0] a);
    return d << (int'(a[2:0]) * 8);
  endfunction

  function automatic logic [7:0] exp_mask(input bit st, input logic [2:0] f3, input logic [63:0] a);
    int base;
    if (!st) return 8'h00;
    case (f3)
      3'b000: base = 1;
      3'b001: base = 3;
      3'b010: base = 15;
      3'b011: return 8'hFF;
      default: return 8'h00;
    endcase
    return 8'((base << int'(a[2:0])) & 255);
  endfunction

  function automatic logic [63:0] exp_load(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] d);
    logic [63:0] s, m, v;
    int n;
    bit sx;
    s = d >> (int'(a[2:0]) * 8);
    case (f3)
      3'b000: begin n = 8;  sx = 1; end
      3'b001: begin n = 16; sx = 1; end
      3'b010: begin n = 32; sx = 1; end
      3'b100: begin n = 8;  sx = 0; end
      3'b101: begin n = 16; sx = 0; end
      3'b110: begin n = 32; sx = 0; end
      default: begin n = 64; sx = 0; end
    endcase
    if (n == 64) return s;
    m = (64'd1 << n) - 64'd1;
    v = s & m;
    if (sx && s[n-1]) v = v | ~m;
    return v;
  endfunction

  // Model: an access is "open" from launch until its response; before the bus
  // takes it, it is "unaccepted".
  bit          m_open = 0, m_acc = 0, m_wen = 0;
  logic [2:0]  m_f3 = '0;
  logic [63:0] m_addr = '0, m_wdata = '0;
  logic [7:0]  m_mask = '0;

  always @(negedge clk) begin
    bit resp;
    resp = m_open && m_acc && mb_rvalid;
    chk("stall", 64'(stall), 64'(valid && (is_load || is_store) && !resp));
    chk("membus_valid", 64'(mb_valid), 64'(!rst && m_open && !m_acc));
    if (rst) begin
      chk("rst_addr", mb_addr, 64'd0);
      chk("rst_wen", 64'(mb_wen), 64'd0);
      chk("rst_wdata", mb_wdata, 64'd0);
      chk("rst_wmask", 64'(mb_wmask), 64'd0);
    end else if (m_open && !m_acc) begin
      chk("bus_addr", mb_addr, m_addr);
      chk("bus_wen", 64'(mb_wen), 64'(m_wen));
      chk("bus_wdata", mb_wdata, m_wdata);
      chk("bus_wmask", 64'(mb_wmask), 64'(m_mask));
    end
    if (!rst && resp && !m_wen)
      chk("rdata", rdata, exp_load(m_f3, m_addr, mb_rdata));
    // inputs are only driven just after posedge, so these are what the next
    // rising edge samples
    if (rst) begin
      m_open = 0; m_acc = 0;
    end else if (!m_open) begin
      if (valid && (is_load || is_store)) begin
        m_open = 1; m_acc = 0; m_wen = is_store; m_f3 = funct3;
        m_addr = addr; m_wdata = exp_wdata(wdata, addr);
        m_mask = exp_mask(is_store, funct3, addr);
      end
    end else if (!m_acc) begin
      if (mb_ready) m_acc = 1;
    end else if (mb_rvalid) begin
      m_open = 0;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Runs one access; returns the bus fields of the last request cycle, the
  // read result and latency (cycles until stall drops, IDLE cycle counted).
  task automatic do_op(input bit ld, input bit st, input logic [2:0] f3,
                       input logic [63:0] a, input logic [63:0] wd, input logic [63:0] rd,
                       input int rdy_dly, input int rv_dly, input bit chg,
                       output logic [63:0] c_addr, output logic [63:0] c_wdata,
                       output logic [7:0] c_mask, output logic c_wen,
                       output logic [63:0] c_rdata, output int c_lat);
    bit done = 0;
    valid = 1; is_load = ld; is_store = st; funct3 = f3; addr = a; wdata = wd;
    mb_rdata = rd; mb_ready = 0; mb_rvalid = 0;
    c_addr = 'x; c_wdata = 'x; c_mask = 'x; c_wen = 1'bx; c_rdata = 'x; c_lat = -1;
    for (int k = 0; k < 60; k++) begin
      mb_ready  = (k >= 1 + rdy_dly);
      mb_rvalid = (k >= 2 + rdy_dly + rv_dly);
      if (chg && k == 3) begin
        addr = a ^ 64'hFF0; wdata = ~wd; funct3 = f3 ^ 3'b001;
      end
      @(negedge clk);
      if (mb_valid) begin
        c_addr = mb_addr; c_wdata = mb_wdata; c_mask = mb_wmask; c_wen = mb_wen;
      end
      if (!stall) begin
        c_rdata = rdata; c_lat = k + 1; done = 1;
        break;
      end
      cyc();
    end
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL op_timeout: stall still %b after 60 cycles, expected 0", stall);
    end
    cyc();
    valid = 0; is_load = 0; is_store = 0; mb_ready = 0; mb_rvalid = 0;
  endtask

  logic [63:0] ca, cw, cr;
  logic [7:0]  cm;
  logic        ce;
  int          cl;

  initial begin
    rst = 1; valid = 0; is_load = 0; is_store = 0; funct3 = 0; addr = 0; wdata = 0;
    mb_ready = 0; mb_rvalid = 0; mb_rdata = 0;
    cyc(); cyc();
    @(negedge clk);
    chk("reset_mvalid", 64'(mb_valid), 64'd0);
    chk("reset_stall", 64'(stall), 64'd0);
    cyc();
    rst = 0;
    cyc();

    // LW sign-extending, immediate handshake
    do_op(1, 0, 3'b010, 64'h1004, 64'h0, 64'h80000000_00000000, 0, 0, 0, ca, cw, cm, ce, cr, cl);
    chk("lw_addr", ca, 64'h1004);
    chk("lw_wen", 64'(ce), 64'd0);
    chk("lw_wmask", 64'(cm), 64'h00);
    chk("lw_rdata", cr, 64'hFFFFFFFF_80000000);
    chk("lw_latency", 64'(cl), 64'd3);

    // SB at lane 3, ack delayed, junk read data ignored
    do_op(0, 1, 3'b000, 64'h2003, 64'hAB, 64'hDEAD_BEEF_0BAD_F00D, 0, 2, 0, ca, cw, cm, ce, cr, cl);
    chk("sb_wdata", cw, 64'hAB000000);
    chk("sb_wmask", 64'(cm), 64'h08);
    chk("sb_wen", 64'(ce), 64'd1);
    chk("sb_latency", 64'(cl), 64'd5);

    // LBU / LH on the top lanes
    do_op(1, 0, 3'b100, 64'h7, 64'h0, 64'hFF00_0000_0000_0000, 0, 0, 0, ca, cw, cm, ce, cr, cl);
    chk("lbu_rdata", cr, 64'hFF);
    do_op(1, 0, 3'b001, 64'h6, 64'h0, 64'hFF00_0000_0000_0000, 0, 0, 0, ca, cw, cm, ce, cr, cl);
    chk("lh_rdata", cr, 64'hFFFFFFFF_FFFFFF00);

    // Backpressure: ready held off 5 cycles, inputs scrambled mid-wait
    do_op(0, 1, 3'b001, 64'h3002, 64'h1234, 64'h0, 5, 0, 1, ca, cw, cm, ce, cr, cl);
    chk("bp_addr", ca, 64'h3002);
    chk("bp_wdata", cw, 64'h12340000);
    chk("bp_wmask", 64'(cm), 64'h0C);
    chk("bp_latency", 64'(cl), 64'd8);

    // Misaligned SW / SD: mask truncated, address untouched
    do_op(0, 1, 3'b010, 64'h4006, 64'h11223344, 64'h0, 1, 1, 0, ca, cw, cm, ce, cr, cl);
    chk("sw_mis_addr", ca, 64'h4006);
    chk("sw_mis_wdata", cw, 64'h33440000_00000000);
    chk("sw_mis_wmask", 64'(cm), 64'hC0);
    do_op(0, 1, 3'b011, 64'h5005, 64'h01020304_05060708, 64'h0, 0, 0, 0, ca, cw, cm, ce, cr, cl);
    chk("sd_mis_wdata", cw, 64'h06070800_00000000);
    chk("sd_mis_wmask", 64'(cm), 64'hFF);

    // funct3=111: store with empty mask, load as LD
    do_op(0, 1, 3'b111, 64'h10, 64'h55, 64'h0, 0, 0, 0, ca, cw, cm, ce, cr, cl);
    chk("f7_st_wmask", 64'(cm), 64'h00);
    chk("f7_st_wen", 64'(ce), 64'd1);
    do_op(1, 0, 3'b111, 64'h18, 64'h0, 64'hDEADBEEF_CAFEF00D, 0, 0, 0, ca, cw, cm, ce, cr, cl);
    chk("f7_ld_rdata", cr, 64'hDEADBEEF_CAFEF00D);

    // Word/half/byte variants
    do_op(1, 0, 3'b110, 64'h4, 64'h0, 64'h89ABCDEF_00000000, 0, 1, 0, ca, cw, cm, ce, cr, cl);
    chk("lwu_rdata", cr, 64'h00000000_89ABCDEF);
    do_op(1, 0, 3'b010, 64'h4, 64'h0, 64'h89ABCDEF_00000000, 2, 0, 0, ca, cw, cm, ce, cr, cl);
    chk("lw_neg_rdata", cr, 64'hFFFFFFFF_89ABCDEF);
    do_op(1, 0, 3'b101, 64'h2, 64'h0, 64'h00000000_80010000, 0, 0, 0, ca, cw, cm, ce, cr, cl);
    chk("lhu_rdata", cr, 64'h8001);
    do_op(1, 0, 3'b000, 64'h1, 64'h0, 64'h00000000_00007F00, 0, 0, 0, ca, cw, cm, ce, cr, cl);
    chk("lb_rdata", cr, 64'h7F);

    // Reset pulsed in WAIT_RVALID, then a late rvalid must be ignored
    valid = 1; is_load = 1; funct3 = 3'b011; addr = 64'h40; mb_ready = 1; mb_rvalid = 0;
    cyc();            // launch
    cyc();            // accepted
    rst = 1; valid = 0; is_load = 0;
    @(negedge clk);
    chk("rst_mid_mvalid", 64'(mb_valid), 64'd0);
    cyc();
    rst = 0; mb_ready = 0; mb_rvalid = 1;
    @(negedge clk);
    chk("post_rst_mvalid", 64'(mb_valid), 64'd0);
    chk("post_rst_stall", 64'(stall), 64'd0);
    cyc(); cyc();
    mb_rvalid = 0;
    @(negedge clk);
    chk("late_rvalid_mvalid", 64'(mb_valid), 64'd0);
    cyc();
    do_op(1, 0, 3'b011, 64'h0, 64'h0, 64'h01234567_89ABCDEF, 0, 0, 0, ca, cw, cm, ce, cr, cl);
    chk("after_rst_rdata", cr, 64'h01234567_89ABCDEF);
    chk("after_rst_latency", 64'(cl), 64'd3);

    // Non-memory instruction never touches the bus
    valid = 1; is_load = 0; is_store = 0; addr = 64'h99; mb_ready = 1; mb_rvalid = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("nonmem_stall", 64'(stall), 64'd0);
      chk("nonmem_mvalid", 64'(mb_valid), 64'd0);
      cyc();
    end
    valid = 0; mb_ready = 0; mb_rvalid = 0;
    cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
